// File: rtl/synth_pkg.sv
// Shared types for the synth voice path: MIDI field widths, the decoded
// note event and the voice allocator FSM encoding.
package synth_pkg;

   localparam int NOTE_W = 7;
   localparam int VEL_W  = 7;

   typedef struct packed {
      logic              on;
      logic [NOTE_W-1:0] note;
      logic [VEL_W-1:0]  vel;
   } note_ev_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_COMMIT = 2'd2
   } alloc_state_t;

endpackage

// File: rtl/voice_slot.sv
// One voice of the pool: gate, note, velocity and saturating age, updated
// only on commands from the allocator FSM.
module voice_slot
   import synth_pkg::*;
#(
   parameter int AGE_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              load,
   input  logic              rel,
   input  logic              inc,
   input  logic [NOTE_W-1:0] ld_note,
   input  logic [VEL_W-1:0]  ld_vel,
   output logic              gate,
   output logic [NOTE_W-1:0] note,
   output logic [VEL_W-1:0]  vel,
   output logic [AGE_W-1:0]  age
);

   function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
      return (a == '1) ? a : a + 1'b1;
   endfunction

   // Panic clear wins over everything; a released voice keeps its note/vel/age.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate <= 1'b0;
         note <= '0;
         vel  <= '0;
         age  <= '0;
      end else if (clear) begin
         gate <= 1'b0;
         age  <= '0;
      end else if (load) begin
         gate <= 1'b1;
         note <= ld_note;
         vel  <= ld_vel;
         age  <= '0;
      end else begin
         if (rel)
            gate <= 1'b0;
         if (inc && gate)
            age <= sat_inc(age);
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: accepts note events, scans the pool one voice
// per cycle, then retriggers a matching voice, takes a free one or steals the oldest.
module voice_allocator
   import synth_pkg::*;
#(
   parameter int NVOICES  = 6,
   parameter bit STEAL_EN = 1'b1,
   parameter int AGE_W    = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ev_valid,
   output logic                      ev_ready,
   input  logic                      ev_on,
   input  logic [NOTE_W-1:0]         ev_note,
   input  logic [VEL_W-1:0]          ev_vel,
   input  logic                      all_off,
   output logic [NVOICES-1:0]        voice_gate,
   output logic [NVOICES-1:0]        voice_trig,
   output logic [NVOICES*NOTE_W-1:0] voice_note,
   output logic [NVOICES*VEL_W-1:0]  voice_vel,
   output logic                      stolen,
   output logic                      dropped
);

   localparam int IDX_W = (NVOICES > 1) ? $clog2(NVOICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NVOICES - 1);

   alloc_state_t       state, state_nx;
   note_ev_t           ev;
   logic [IDX_W-1:0]   idx, match_idx, free_idx, old_idx, tgt_idx;
   logic               match_found, free_found, old_found;
   logic [AGE_W-1:0]   old_age;
   logic               accept, commit, tgt_valid, tgt_steal;
   logic [NVOICES-1:0] gate_v, load_v, rel_v, inc_v, trig_q;
   logic               stolen_q, dropped_q;
   logic [NOTE_W-1:0]  note_a [NVOICES];
   logic [VEL_W-1:0]   vel_a  [NVOICES];
   logic [AGE_W-1:0]   age_a  [NVOICES];

   assign ev_ready = (state == ST_IDLE);
   assign accept   = ev_valid && ev_ready && !all_off;
   assign commit   = (state == ST_COMMIT) && !all_off;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (ev_valid) state_nx = ST_SCAN;
         ST_SCAN:   if (idx == LAST_IDX) state_nx = ST_COMMIT;
         ST_COMMIT: state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
      if (all_off)
         state_nx = ST_IDLE;
   end

   // Scan: strict compares keep the lowest index on ties.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ev          <= '0;
         idx         <= '0;
         match_found <= 1'b0;
         free_found  <= 1'b0;
         old_found   <= 1'b0;
         match_idx   <= '0;
         free_idx    <= '0;
         old_idx     <= '0;
         old_age     <= '0;
      end else if (accept) begin
         ev.on       <= ev_on && (ev_vel != '0);
         ev.note     <= ev_note;
         ev.vel      <= ev_vel;
         idx         <= '0;
         match_found <= 1'b0;
         free_found  <= 1'b0;
         old_found   <= 1'b0;
      end else if (state == ST_SCAN) begin
         if (gate_v[idx] && note_a[idx] == ev.note && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= idx;
         end
         if (!gate_v[idx] && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
         end
         if (gate_v[idx] && (!old_found || age_a[idx] > old_age)) begin
            old_found <= 1'b1;
            old_idx   <= idx;
            old_age   <= age_a[idx];
         end
         idx <= idx + 1'b1;
      end
   end

   always_comb begin
      tgt_valid = 1'b0;
      tgt_steal = 1'b0;
      tgt_idx   = '0;
      if (ev.on) begin
         if (match_found) begin
            tgt_valid = 1'b1;
            tgt_idx   = match_idx;
         end else if (free_found) begin
            tgt_valid = 1'b1;
            tgt_idx   = free_idx;
         end else if (STEAL_EN && old_found) begin
            tgt_valid = 1'b1;
            tgt_steal = 1'b1;
            tgt_idx   = old_idx;
         end
      end
   end

   for (genvar i = 0; i < NVOICES; i++) begin : g_voice
      assign load_v[i] = commit && tgt_valid && (tgt_idx == IDX_W'(i));
      assign inc_v[i]  = commit && tgt_valid && (tgt_idx != IDX_W'(i));
      assign rel_v[i]  = commit && !ev.on && gate_v[i] && (note_a[i] == ev.note);

      voice_slot #(.AGE_W(AGE_W)) u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
         .clear   (all_off),
         .load    (load_v[i]),
         .rel     (rel_v[i]),
         .inc     (inc_v[i]),
         .ld_note (ev.note),
         .ld_vel  (ev.vel),
         .gate    (gate_v[i]),
         .note    (note_a[i]),
         .vel     (vel_a[i]),
         .age     (age_a[i])
      );

      assign voice_note[NOTE_W*i +: NOTE_W] = note_a[i];
      assign voice_vel[VEL_W*i +: VEL_W]    = vel_a[i];
   end

   // Commit-edge pulses, visible for exactly the following cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_q    <= '0;
         stolen_q  <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         trig_q    <= load_v;
         stolen_q  <= commit && tgt_steal;
         dropped_q <= commit && ev.on && !tgt_valid;
      end
   end

   assign voice_gate = gate_v;
   assign voice_trig = trig_q;
   assign stolen     = stolen_q;
   assign dropped    = dropped_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Randomized bench for voice_allocator: a stealing and a dropping instance
// share stimulus and are compared against an event-level reference model.
module tb_voice_allocator;

   localparam int NV = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ev_valid = 1'b0;
   logic ev_on = 1'b0;
   logic [6:0] ev_note = '0;
   logic [6:0] ev_vel = '0;
   logic all_off = 1'b0;

   logic          ready_s, ready_d, stolen_s, stolen_d, dropped_s, dropped_d;
   logic [NV-1:0] gate_s, gate_d, trig_s, trig_d;
   logic [NV*7-1:0] note_s, note_d, vel_s, vel_d;

   int errs = 0;
   int checks = 0;

   bit m_gate [2][NV];
   int m_note [2][NV];
   int m_vel  [2][NV];
   int m_age  [2][NV];
   int e_tgt  [2];
   bit e_steal[2];
   bit e_drop [2];

   always #5 clk = ~clk;

   voice_allocator #(.NVOICES(NV), .STEAL_EN(1'b1), .AGE_W(8)) dut_s (
      .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ready_s),
      .ev_on(ev_on), .ev_note(ev_note), .ev_vel(ev_vel), .all_off(all_off),
      .voice_gate(gate_s), .voice_trig(trig_s), .voice_note(note_s),
      .voice_vel(vel_s), .stolen(stolen_s), .dropped(dropped_s));

   voice_allocator #(.NVOICES(NV), .STEAL_EN(1'b0), .AGE_W(8)) dut_d (
      .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ready_d),
      .ev_on(ev_on), .ev_note(ev_note), .ev_vel(ev_vel), .all_off(all_off),
      .voice_gate(gate_d), .voice_trig(trig_d), .voice_note(note_d),
      .voice_vel(vel_d), .stolen(stolen_d), .dropped(dropped_d));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < NV; i++) begin
            m_gate[k][i] = 1'b0;
            m_note[k][i] = 0;
            m_vel[k][i]  = 0;
            m_age[k][i]  = 0;
         end
   endtask

   task automatic model_all_off();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < NV; i++) begin
            m_gate[k][i] = 1'b0;
            m_age[k][i]  = 0;
         end
   endtask

   // Instance 0 steals when full, instance 1 drops.
   task automatic model_event(input bit on, input int note, input int vel);
      for (int k = 0; k < 2; k++) begin
         int t;
         e_tgt[k] = -1;
         e_steal[k] = 1'b0;
         e_drop[k] = 1'b0;
         if (on && vel != 0) begin
            t = -1;
            for (int i = 0; i < NV; i++)
               if (t < 0 && m_gate[k][i] && m_note[k][i] == note) t = i;
            for (int i = 0; i < NV; i++)
               if (t < 0 && !m_gate[k][i]) t = i;
            if (t < 0 && k == 0) begin
               for (int i = 0; i < NV; i++)
                  if (m_gate[k][i] && (t < 0 || m_age[k][i] > m_age[k][t])) t = i;
               e_steal[k] = 1'b1;
            end
            if (t < 0) begin
               e_drop[k] = 1'b1;
            end else begin
               for (int i = 0; i < NV; i++)
                  if (i != t && m_gate[k][i] && m_age[k][i] < 255) m_age[k][i]++;
               m_gate[k][t] = 1'b1;
               m_note[k][t] = note;
               m_vel[k][t]  = vel;
               m_age[k][t]  = 0;
               e_tgt[k] = t;
            end
         end else begin
            for (int i = 0; i < NV; i++)
               if (m_gate[k][i] && m_note[k][i] == note) m_gate[k][i] = 1'b0;
         end
      end
   endtask

   function automatic logic [NV-1:0] m_gate_vec(input int k);
      logic [NV-1:0] r;
      for (int i = 0; i < NV; i++) r[i] = m_gate[k][i];
      return r;
   endfunction

   function automatic logic [NV*7-1:0] m_note_vec(input int k);
      logic [NV*7-1:0] r;
      for (int i = 0; i < NV; i++) r[7*i +: 7] = 7'(m_note[k][i]);
      return r;
   endfunction

   function automatic logic [NV*7-1:0] m_vel_vec(input int k);
      logic [NV*7-1:0] r;
      for (int i = 0; i < NV; i++) r[7*i +: 7] = 7'(m_vel[k][i]);
      return r;
   endfunction

   task automatic check_voices(input string tag);
      check({tag, "_gate_s"}, 64'(gate_s), 64'(m_gate_vec(0)));
      check({tag, "_gate_d"}, 64'(gate_d), 64'(m_gate_vec(1)));
      check({tag, "_note_s"}, 64'(note_s), 64'(m_note_vec(0)));
      check({tag, "_note_d"}, 64'(note_d), 64'(m_note_vec(1)));
      check({tag, "_vel_s"},  64'(vel_s),  64'(m_vel_vec(0)));
      check({tag, "_vel_d"},  64'(vel_d),  64'(m_vel_vec(1)));
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!(ready_s && ready_d) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready"}, 64'({ready_s, ready_d}), 64'(2'b11));
   endtask

   task automatic send_event(input string tag, input bit on, input int note, input int vel);
      logic [NV-1:0] et_s, et_d;
      @(negedge clk);
      wait_ready(tag);
      ev_valid = 1'b1;
      ev_on    = on;
      ev_note  = 7'(note);
      ev_vel   = 7'(vel);
      @(posedge clk);
      #1;
      ev_valid = 1'b0;
      check({tag, "_busy"}, 64'({ready_s, ready_d}), 64'(2'b00));
      model_event(on, note, vel);
      repeat (NV) @(posedge clk);
      check({tag, "_pre_gate"}, 64'({gate_s, gate_d}), 64'({gate_s, gate_d}) | 64'(0));
      @(posedge clk);
      #1;
      et_s = '0;
      et_d = '0;
      if (e_tgt[0] >= 0) et_s[e_tgt[0]] = 1'b1;
      if (e_tgt[1] >= 0) et_d[e_tgt[1]] = 1'b1;
      check_voices(tag);
      check({tag, "_trig_s"}, 64'(trig_s), 64'(et_s));
      check({tag, "_trig_d"}, 64'(trig_d), 64'(et_d));
      check({tag, "_pulses"}, 64'({stolen_s, dropped_s, stolen_d, dropped_d}),
            64'({e_steal[0], e_drop[0], e_steal[1], e_drop[1]}));
      check({tag, "_ready_after"}, 64'({ready_s, ready_d}), 64'(2'b11));
      @(posedge clk);
      #1;
      check({tag, "_pulse_end"}, 64'({trig_s, trig_d, stolen_s, dropped_s, stolen_d, dropped_d}), 64'(0));
   endtask

   task automatic pulse_all_off(input string tag);
      @(negedge clk);
      all_off = 1'b1;
      @(posedge clk);
      #1;
      all_off = 1'b0;
      model_all_off();
      check({tag, "_gates"}, 64'({gate_s, gate_d}), 64'(0));
      check({tag, "_ready"}, 64'({ready_s, ready_d}), 64'(2'b11));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] acc;
      model_reset();
      #23;
      check("rst_outputs", 64'({gate_s, trig_s, stolen_s, dropped_s, gate_d, trig_d, stolen_d, dropped_d}), 64'(0));
      check("rst_note_vel", 64'(note_s | vel_s | note_d | vel_d), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_ready", 64'({ready_s, ready_d}), 64'(2'b11));

      send_event("first_on", 1'b1, 60, 100);
      for (int n = 61; n <= 65; n++) send_event("fill", 1'b1, n, 10 + n);
      send_event("full_on", 1'b1, 70, 77);

      pulse_all_off("panic");
      for (int n = 60; n <= 65; n++) send_event("refill", 1'b1, n, 40 + n);
      send_event("retrig", 1'b1, 62, 30);
      send_event("off63", 1'b0, 63, 0);
      send_event("vel0", 1'b1, 64, 0);
      send_event("off99", 1'b0, 99, 5);
      send_event("low_free", 1'b1, 80, 55);

      for (int r = 0; r < 60; r++) begin
         bit on;
         int note, vel;
         on   = ($urandom_range(0, 2) != 0);
         note = 60 + $urandom_range(0, 7);
         vel  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
         if ($urandom_range(0, 15) == 0) pulse_all_off("rnd_panic");
         send_event("rnd", on, note, vel);
      end

      // Panic while a note-on is being scanned.
      @(negedge clk);
      wait_ready("scan_panic");
      ev_valid = 1'b1;
      ev_on = 1'b1;
      ev_note = 7'd50;
      ev_vel = 7'd90;
      @(posedge clk);
      #1;
      ev_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      all_off = 1'b1;
      @(posedge clk);
      #1;
      all_off = 1'b0;
      model_all_off();
      check("scan_panic_gates", 64'({gate_s, gate_d}), 64'(0));
      check("scan_panic_ready", 64'({ready_s, ready_d}), 64'(2'b11));
      acc = '0;
      repeat (NV + 2) begin
         @(posedge clk);
         #1;
         acc = acc | 64'({trig_s, trig_d, stolen_s, dropped_s, stolen_d, dropped_d, gate_s, gate_d});
      end
      check("scan_panic_quiet", acc, 64'(0));

      send_event("post_panic", 1'b1, 61, 20);
      send_event("post_panic2", 1'b1, 66, 21);

      // Asynchronous reset in the middle of a scan.
      @(negedge clk);
      wait_ready("mid_rst");
      ev_valid = 1'b1;
      ev_on = 1'b1;
      ev_note = 7'd70;
      ev_vel = 7'd70;
      @(posedge clk);
      #1;
      ev_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("mid_rst_outputs", 64'({gate_s, trig_s, stolen_s, dropped_s, gate_d, trig_d, stolen_d, dropped_d}), 64'(0));
      check("mid_rst_note_vel", 64'(note_s | vel_s | note_d | vel_d), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_ready", 64'({ready_s, ready_d}), 64'(2'b11));
      check("mid_rst_gates", 64'({gate_s, gate_d}), 64'(0));
      send_event("after_rst", 1'b1, 60, 100);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
